// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and default payload width.
// Imported by uart_rx and intended for reuse by the matching transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS_DEF = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// RESET_VAL lets an idle-high serial line come out of reset without a false edge.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit centre search, mid-bit data sampling, stop-bit check.
// Outputs are registered; data_valid and frame_err are single-cycle, mutually exclusive pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy,
    output uart_state_e          o_dbg_state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic                 w_rx_s;
    logic                 r_rx_d;
    uart_state_e          r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_data_valid;
    logic                 r_frame_err;
    logic                 r_busy;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (rx),
        .o_sync  (w_rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_d       <= 1'b1;
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_rx_d       <= w_rx_s;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;

            case (r_state)
                IDLE: begin
                    // A held-low line (break) never shows rx_d=1, so it cannot retrigger.
                    if (r_rx_d && !w_rx_s) begin
                        r_state   <= START;
                        r_cnt     <= '0;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end

                START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state <= DATA;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state   <= STOP;
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        if (w_rx_s) begin
                            r_data_out   <= r_shift;
                            r_data_valid <= 1'b1;
                        end else begin
                            r_frame_err  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out    = r_data_out;
    assign data_valid  = r_data_valid;
    assign frame_err   = r_frame_err;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule
